fan_ctrl: RTL and testbench



---
 rtl/fan_ctrl_if.sv | 32 +++
 rtl/fan_ctrl.sv | 121 ++++++++++++
 tb/tb_fan_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fan_ctrl_if.sv
// Signal bundle between the fan controller and its surroundings: ADC/setpoint
// samples, PID coefficients, PWM limits and the two controller outputs.
interface fan_ctrl_if #(
  parameter int ADC_BITWIDTH = 8,
  parameter int REG_BITWIDTH = 35
);
  logic                           clk_en_PWM_i;
  logic                           dataValid_STRB_i;
  logic        [ADC_BITWIDTH:0]   periodCounterValue_i;
  logic        [ADC_BITWIDTH-1:0] minCounterValue_i;
  logic        [ADC_BITWIDTH-1:0] ADC_value_i;
  logic        [ADC_BITWIDTH-1:0] SET_value_i;
  logic signed [REG_BITWIDTH-1:0] a0_i;
  logic signed [REG_BITWIDTH-1:0] a1_i;
  logic signed [REG_BITWIDTH-1:0] b0_i;
  logic signed [REG_BITWIDTH-1:0] b1_i;
  logic signed [REG_BITWIDTH-1:0] b2_i;
  logic                           PWM_pin_o;
  logic signed [ADC_BITWIDTH:0]   PID_Val_o;

  modport master (
    output clk_en_PWM_i, dataValid_STRB_i, periodCounterValue_i, minCounterValue_i,
    output ADC_value_i, SET_value_i, a0_i, a1_i, b0_i, b1_i, b2_i,
    input  PWM_pin_o, PID_Val_o
  );

  modport slave (
    input  clk_en_PWM_i, dataValid_STRB_i, periodCounterValue_i, minCounterValue_i,
    input  ADC_value_i, SET_value_i, a0_i, a1_i, b0_i, b1_i, b2_i,
    output PWM_pin_o, PID_Val_o
  );
endinterface

// File: rtl/fan_ctrl.sv
// Closed-loop fan controller: direct-form IIR PID with saturating anti-windup
// feedback driving a registered PWM pin. FANCTRL_PWM_SYNC_EN latches duty per period.
module fan_ctrl #(
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 35,
  parameter int FRAC_BITWIDTH = 30
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  fan_ctrl_if.slave bus
);
  localparam int EW = ADC_BITWIDTH + 1;
  localparam int PW = REG_BITWIDTH + EW;
  localparam int SW = REG_BITWIDTH + ADC_BITWIDTH + 4;
  localparam logic signed [EW-1:0] Y_MAX = {1'b0, {ADC_BITWIDTH{1'b1}}};

  // dataValid_STRB_i is a qualifier without back-pressure: each high cycle
  // consumes exactly one sample and the result is on PID_Val_o after that edge.
  logic signed [EW-1:0] e0;
  logic signed [EW-1:0] e1_q, e2_q, y1_q, y2_q;
  logic signed [EW-1:0] y_sat;
  logic signed [PW-1:0] p_b2, p_b1, p_b0, p_a1, p_a0;
  logic signed [SW-1:0] acc, acc_sh;

  assign e0 = $signed({1'b0, bus.SET_value_i}) - $signed({1'b0, bus.ADC_value_i});

  assign p_b2 = PW'(bus.b2_i) * PW'(e0);
  assign p_b1 = PW'(bus.b1_i) * PW'(e1_q);
  assign p_b0 = PW'(bus.b0_i) * PW'(e2_q);
  assign p_a1 = PW'(bus.a1_i) * PW'(y1_q);
  assign p_a0 = PW'(bus.a0_i) * PW'(y2_q);

  assign acc    = SW'(p_b2) + SW'(p_b1) + SW'(p_b0) - SW'(p_a1) - SW'(p_a0);
  assign acc_sh = acc >>> FRAC_BITWIDTH;

  always_comb begin
    y_sat = '0;
    if (acc_sh[SW-1]) begin
      y_sat = '0;
    end else if (|acc_sh[SW-2:ADC_BITWIDTH]) begin
      y_sat = Y_MAX;
    end else begin
      y_sat = {1'b0, acc_sh[ADC_BITWIDTH-1:0]};
    end
  end

  // The saturated output is what re-enters the recursion, so the filter
  // state can never wind up beyond the drive range.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      e1_q <= '0;
      e2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
    end else if (bus.dataValid_STRB_i) begin
      e2_q <= e1_q;
      e1_q <= e0;
      y2_q <= y1_q;
      y1_q <= y_sat;
    end
  end

  assign bus.PID_Val_o = y1_q;

  logic [EW-1:0] cnt_q, cnt_next;
  logic [EW:0]   cnt_inc;
  logic          wrap;
  logic [EW-1:0] duty_c, duty_use;
  logic          pin_q;

  assign duty_c  = {1'b0, bus.minCounterValue_i} + $unsigned(y1_q);
  assign cnt_inc = {1'b0, cnt_q} + {{EW{1'b0}}, 1'b1};

  always_comb begin
    cnt_next = '0;
    wrap     = 1'b0;
    if (bus.periodCounterValue_i != '0) begin
      if (cnt_inc >= {1'b0, bus.periodCounterValue_i}) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = cnt_inc[EW-1:0];
      end
    end
  end

`ifdef FANCTRL_PWM_SYNC_EN
  logic [EW-1:0] duty_sh_q;
  logic          sh_loaded_q;

  // The shadow takes C on the first cycle out of reset and then only on the
  // enabled edge that wraps the counter, which also uses the fresh value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      duty_sh_q   <= '0;
      sh_loaded_q <= 1'b0;
    end else begin
      sh_loaded_q <= 1'b1;
      if (!sh_loaded_q || (bus.clk_en_PWM_i && wrap)) begin
        duty_sh_q <= duty_c;
      end
    end
  end

  assign duty_use = (!sh_loaded_q || wrap) ? duty_c : duty_sh_q;
`else
  assign duty_use = duty_c;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      pin_q <= 1'b0;
    end else if (bus.clk_en_PWM_i) begin
      cnt_q <= cnt_next;
      pin_q <= (bus.periodCounterValue_i != '0) && (cnt_next < duty_use);
    end
  end

  assign bus.PWM_pin_o = pin_q;
endmodule

// File: tb/tb_fan_ctrl.sv
// Directed and randomized bench for fan_ctrl: PID results and PWM duty counts
// are queued as expectations and compared when the DUT produces them.
module tb_fan_ctrl;
  localparam int ADC_BITWIDTH  = 8;
  localparam int REG_BITWIDTH  = 35;
  localparam int FRAC_BITWIDTH = 30;
  localparam int EW            = ADC_BITWIDTH + 1;
  localparam longint ONE       = 64'sd1073741824;

  // clock / reset
  logic clk_tb = 1'b0;
  logic rstn;
  always #5 clk_tb = ~clk_tb;

  fan_ctrl_if #(.ADC_BITWIDTH(ADC_BITWIDTH), .REG_BITWIDTH(REG_BITWIDTH)) bus ();

  fan_ctrl #(
    .ADC_BITWIDTH (ADC_BITWIDTH),
    .REG_BITWIDTH (REG_BITWIDTH),
    .FRAC_BITWIDTH(FRAC_BITWIDTH)
  ) dut (
    .clk_i (clk_tb),
    .rstn_i(rstn),
    .bus   (bus.slave)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  longint m_e1, m_e2, m_y1, m_y2;
  longint c_a0, c_a1, c_b0, c_b1, c_b2;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint model_step(input longint e);
    longint acc, q;
    acc = c_b2 * e + c_b1 * m_e1 + c_b0 * m_e2 - c_a1 * m_y1 - c_a0 * m_y2;
    q = acc >>> FRAC_BITWIDTH;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    m_e2 = m_e1;
    m_e1 = e;
    m_y2 = m_y1;
    m_y1 = q;
    return q;
  endfunction

  // driver tasks
  task automatic set_coef(input longint a0, input longint a1, input longint b0,
                          input longint b1, input longint b2);
    c_a0 = a0; c_a1 = a1; c_b0 = b0; c_b1 = b1; c_b2 = b2;
    bus.a0_i = 35'(a0);
    bus.a1_i = 35'(a1);
    bus.b0_i = 35'(b0);
    bus.b1_i = 35'(b1);
    bus.b2_i = 35'(b2);
  endtask

  task automatic rand_inputs();
    bus.clk_en_PWM_i         = 1'($urandom_range(0, 1));
    bus.dataValid_STRB_i     = 1'($urandom_range(0, 1));
    bus.periodCounterValue_i = 9'($urandom);
    bus.minCounterValue_i    = 8'($urandom);
    bus.ADC_value_i          = 8'($urandom);
    bus.SET_value_i          = 8'($urandom);
    bus.a0_i = 35'({$urandom, $urandom});
    bus.a1_i = 35'({$urandom, $urandom});
    bus.b0_i = 35'({$urandom, $urandom});
    bus.b1_i = 35'({$urandom, $urandom});
    bus.b2_i = 35'({$urandom, $urandom});
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_pid", bus.PID_Val_o, '0);
    check("rst_async_pin", {8'd0, bus.PWM_pin_o}, '0);
    repeat (3) begin
      @(negedge clk_tb);
      rand_inputs();
    end
    @(posedge clk_tb);
    #1;
    check("rst_hold_pid", bus.PID_Val_o, '0);
    check("rst_hold_pin", {8'd0, bus.PWM_pin_o}, '0);
    @(negedge clk_tb);
    bus.dataValid_STRB_i = 1'b0;
    bus.clk_en_PWM_i     = 1'b0;
    rstn = 1'b1;
    m_e1 = 0; m_e2 = 0; m_y1 = 0; m_y2 = 0;
    repeat (2) @(posedge clk_tb);
    #1;
    check("rst_release_pid", bus.PID_Val_o, '0);
    check("rst_release_pin", {8'd0, bus.PWM_pin_o}, '0);
  endtask

  // directed < 0 means the expectation comes from the reference model
  task automatic pid_step(input int set, input int adc, input int directed, input string tag);
    longint m;
    @(negedge clk_tb);
    bus.SET_value_i      = 8'(set);
    bus.ADC_value_i      = 8'(adc);
    bus.dataValid_STRB_i = 1'b1;
    m = model_step(longint'(set) - longint'(adc));
    if (directed < 0) exp_q.push_back(EW'(m));
    else              exp_q.push_back(EW'(directed));
    @(posedge clk_tb);
    #1;
    check(tag, bus.PID_Val_o, exp_q.pop_front());
  endtask

  task automatic strobe_off();
    @(negedge clk_tb);
    bus.dataValid_STRB_i = 1'b0;
  endtask

  // runs until 'ticks' enabled edges; pin must not move on disabled edges
  task automatic pwm_window(input int ticks, output int highs, output int bad);
    int done;
    logic prev, en;
    highs = 0;
    bad   = 0;
    done  = 0;
    for (int i = 0; i < ticks * 20 && done < ticks; i++) begin
      @(negedge clk_tb);
      en = 1'($urandom_range(0, 1));
      bus.clk_en_PWM_i = en;
      prev = bus.PWM_pin_o;
      @(posedge clk_tb);
      #1;
      if (en) begin
        done++;
        if (bus.PWM_pin_o === 1'b1) highs++;
      end else if (bus.PWM_pin_o !== prev) begin
        bad++;
      end
    end
    if (done < ticks) bad++;
    @(negedge clk_tb);
    bus.clk_en_PWM_i = 1'b0;
  endtask

  task automatic pwm_measure(input int expect_highs, input string tag);
    int highs, bad, h_w, b_w;
    pwm_window(320, h_w, b_w);
    exp_q.push_back(EW'(expect_highs));
    exp_q.push_back('0);
    pwm_window(320, highs, bad);
    check({tag, "_highs"}, EW'(highs), exp_q.pop_front());
    check({tag, "_gating"}, EW'(bad + b_w), exp_q.pop_front());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_pin;
    rstn = 1'b0;
    rand_inputs();
    do_reset();

    // proportional only
    set_coef(0, 0, 0, 0, ONE);
    pid_step(20, 100, 0, "prop_neg");
    pid_step(200, 50, 150, "prop_pos");
    strobe_off();

    // integrator with saturation and anti-windup
    do_reset();
    set_coef(0, -ONE, 0, 0, ONE);
    for (int k = 1; k <= 28; k++) pid_step(60, 50, (10 * k > 255) ? 255 : 10 * k, "integ_up");
    for (int k = 1; k <= 5; k++)  pid_step(40, 50, 255 - 10 * k, "integ_down");
    strobe_off();

    // strobe gating
    repeat (5) begin
      @(negedge clk_tb);
      bus.ADC_value_i = 8'($urandom);
      bus.SET_value_i = 8'($urandom);
      @(posedge clk_tb);
      #1;
      check("gate_hold", bus.PID_Val_o, EW'(205));
    end
    pid_step(40, 50, 195, "gate_resume");
    strobe_off();

    // random coefficients against the reference model
    do_reset();
    set_coef(longint'($urandom_range(0, 32'h4000_0000)) - ONE / 2,
             longint'($urandom_range(0, 32'h4000_0000)) - ONE / 2,
             longint'($urandom_range(0, 32'h8000_0000)) - ONE,
             longint'($urandom_range(0, 32'h8000_0000)) - ONE,
             longint'($urandom_range(0, 32'h8000_0000)) - ONE);
    for (int k = 0; k < 20; k++) pid_step($urandom_range(0, 255), $urandom_range(0, 255), -1, "pid_rand");
    strobe_off();

    // PWM minimum duty, full drive, zero duty, zero period
    do_reset();
    bus.periodCounterValue_i = 9'd320;
    bus.minCounterValue_i    = 8'd65;
    set_coef(0, 0, 0, 0, 0);
    pid_step(0, 0, 0, "pwm_pid0");
    strobe_off();
    pwm_measure(65, "pwm_min");
    set_coef(0, 0, 0, 0, ONE);
    pid_step(255, 0, 255, "pwm_pid255");
    strobe_off();
    pwm_measure(320, "pwm_full");
    bus.minCounterValue_i = 8'd0;
    set_coef(0, 0, 0, 0, 0);
    pid_step(0, 0, 0, "pwm_pidz");
    strobe_off();
    pwm_measure(0, "pwm_zero");
    bus.periodCounterValue_i = 9'd0;
    bus.minCounterValue_i    = 8'd100;
    pwm_measure(0, "pwm_period0");

    // duty change in the middle of a period
    do_reset();
    bus.periodCounterValue_i = 9'd320;
    bus.minCounterValue_i    = 8'd0;
    set_coef(0, 0, 0, 0, 0);
    pid_step(0, 0, 0, "mid_pid0");
    strobe_off();
    begin
      int h, b;
      pwm_window(330, h, b);
      check("mid_pre_highs", EW'(h), '0);
    end
    set_coef(0, 0, 0, 0, ONE);
    pid_step(150, 0, 150, "mid_pid150");
    strobe_off();
`ifdef FANCTRL_PWM_SYNC_EN
    exp_pin = 1'b0;
`else
    exp_pin = 1'b1;
`endif
    exp_q.push_back({8'd0, exp_pin});
    @(negedge clk_tb);
    bus.clk_en_PWM_i = 1'b1;
    @(posedge clk_tb);
    #1;
    check("mid_period_pin", {8'd0, bus.PWM_pin_o}, exp_q.pop_front());
    @(negedge clk_tb);
    bus.clk_en_PWM_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
